mult_div_unit: RTL

//  Multi-cycle HI/LO multiply/divide unit for the pipelined MIPS core. Sits in EX beside the ALU.

---
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit for the EX stage.
// The result is computed combinationally at accept and staged. It is then
// committed to HI/LO on the edge where the countdown reaches zero, so the
// architectural registers change only when busy falls.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Handshake: an operation is taken on a posedge where start=1 and busy=0.
    // A start while busy=1 is dropped entirely, so upstream must hold MDU
    // instructions while (busy | start). busy is a flop and never depends on start.

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    logic [CW-1:0] counter;
    logic [31:0]   hi_s;
    logic [31:0]   lo_s;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sq;
    logic [31:0] sr;

    logic          stage_go;
    logic [CW-1:0] stage_cnt;
    logic [31:0]   stage_hi;
    logic [31:0]   stage_lo;

    // Products: sign-extend for MULT, zero-extend for MULTU.
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divides use a substitute divisor of 1 when B==0. Those results are never
    // used, since the staged value then reproduces the current HI/LO instead.
    assign div_b = (B == 32'd0) ? 32'd1 : B;
    assign uq    = A / div_b;
    assign ur    = A % div_b;

    // Signed divide works on magnitudes. 0x80000000 / -1 falls out naturally as
    // a magnitude of 0x80000000, whose negation is itself, with a remainder of 0.
    assign abs_a = A[31] ? (~A + 32'd1) : A;
    assign abs_b = div_b[31] ? (~div_b + 32'd1) : div_b;
    assign mag_q = abs_a / abs_b;
    assign mag_r = abs_a % abs_b;
    assign sq    = (A[31] ^ B[31]) ? (~mag_q + 32'd1) : mag_q;
    assign sr    = A[31] ? (~mag_r + 32'd1) : mag_r;

    // Select the staged result and the busy length for a multi-cycle op.
    always_comb begin
        stage_go  = 1'b0;
        stage_cnt = '0;
        stage_hi  = HI;
        stage_lo  = LO;
        case (mdu_op_e'(MDUOp))
            OP_MULT: begin
                stage_go  = 1'b1;
                stage_cnt = MULT_CNT;
                stage_hi  = prod_s[63:32];
                stage_lo  = prod_s[31:0];
            end
            OP_MULTU: begin
                stage_go  = 1'b1;
                stage_cnt = MULT_CNT;
                stage_hi  = prod_u[63:32];
                stage_lo  = prod_u[31:0];
            end
            OP_DIV: begin
                stage_go  = 1'b1;
                stage_cnt = DIV_CNT;
                if (B != 32'd0) begin
                    stage_hi = sr;
                    stage_lo = sq;
                end
            end
            OP_DIVU: begin
                stage_go  = 1'b1;
                stage_cnt = DIV_CNT;
                if (B != 32'd0) begin
                    stage_hi = ur;
                    stage_lo = uq;
                end
            end
            default: begin
                stage_go = 1'b0;
            end
        endcase
    end

    // Accept, count down, and commit the staged result as busy falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            busy    <= 1'b0;
            hi_s    <= 32'd0;
            lo_s    <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (start && !busy) begin
            if (stage_go) begin
                counter <= stage_cnt;
                busy    <= 1'b1;
                hi_s    <= stage_hi;
                lo_s    <= stage_lo;
            end else if (MDUOp == OP_MTHI) begin
                HI <= A;
            end else if (MDUOp == OP_MTLO) begin
                LO <= A;
            end
        end else if (counter != '0) begin
            counter <= counter - CNT_ONE;
            if (counter == CNT_ONE) begin
                busy <= 1'b0;
                HI   <= hi_s;
                LO   <= lo_s;
            end
        end
    end

endmodule
